// File: rtl/register_write_arbiter_if.sv
// Bus bundle between N write requesters and the shared-register arbiter.
// Optional last_writer signal exists only when REG_ARB_LAST_WRITER_EN is defined.
interface register_write_arbiter_if #(
    parameter int W = 16,
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Handshake: a requester holds req[i] and its data slice stable until
    // ack[i] pulses for one cycle; req[i] must drop in the cycle after ack.
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic           busy;
    logic [W-1:0]   out_reg;
    logic           state_dbg;
`ifdef REG_ARB_LAST_WRITER_EN
    logic [IW-1:0]  last_writer;
`endif

`ifdef REG_ARB_LAST_WRITER_EN
    modport master (output req, req_data,
                    input  ack, busy, out_reg, state_dbg, last_writer);
    modport slave  (input  req, req_data,
                    output ack, busy, out_reg, state_dbg, last_writer);
`else
    modport master (output req, req_data,
                    input  ack, busy, out_reg, state_dbg);
    modport slave  (input  req, req_data,
                    output ack, busy, out_reg, state_dbg);
`endif
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter serialising N requesters' writes into one W-bit register.
// Define REG_ARB_LAST_WRITER_EN to add the last_writer register and port.
module register_write_arbiter #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  reset_synchronous_n,
    register_write_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [IW-1:0] p_q, p_d;
    logic [W-1:0]  data_q, data_d;
    logic [W-1:0]  out_reg_q, out_reg_d;

    logic [W-1:0]  slot [N];
    logic          found;
    logic [IW-1:0] winner;
    logic [IW-1:0] idx;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            slot[i] = bus.req_data[i*W +: W];
        end
    end

    // Search upward from the pointer, wrapping; first asserted request wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(p_q) + k) % N);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        data_d     = data_q;
        p_d        = p_q;
        out_reg_d  = out_reg_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = winner;
                    data_d     = slot[winner];
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                out_reg_d = data_q;
                p_d       = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + IW'(1);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_synchronous_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            p_q        <= '0;
            data_q     <= '0;
            out_reg_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            p_q        <= p_d;
            data_q     <= data_d;
            out_reg_q  <= out_reg_d;
        end
    end

`ifdef REG_ARB_LAST_WRITER_EN
    logic [IW-1:0] last_writer_q, last_writer_d;

    always_comb begin
        last_writer_d = last_writer_q;
        if (state_q == WRITE) begin
            last_writer_d = grant_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_synchronous_n) begin
            last_writer_q <= '0;
        end else begin
            last_writer_q <= last_writer_d;
        end
    end

    assign bus.last_writer = last_writer_q;
`endif

    // Outputs decode only registered state, so req never reaches them combinationally.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.ack[i] = (state_q == WRITE) && (grant_id_q == IW'(i));
        end
    end

    assign bus.busy      = (state_q == WRITE);
    assign bus.out_reg   = out_reg_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter: driver pushes expected grants,
// a negedge monitor pops them on every ack and checks the committed value.
module tb_register_write_arbiter;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int EW = N + W + IW;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    register_write_arbiter_if #(.W(W), .N(N)) bus ();

    register_write_arbiter #(.W(W), .N(N)) dut (
        .clk                 (clk),
        .reset_synchronous_n (rst_n),
        .bus                 (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] data, input logic [IW-1:0] lw);
        logic [N-1:0] a;
        a     = '0;
        a[id] = 1'b1;
        exp_q.push_back({a, data, lw});
    endtask

    task automatic set_slot(input int id, input logic [W-1:0] data);
        bus.req_data[id*W +: W] = data;
    endtask

    // monitor
    logic          pend = 1'b0;
    logic [W-1:0]  pend_data;
    logic [IW-1:0] pend_lw;
    logic [EW-1:0] e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pend) begin
                check("out_reg_commit", 32'(bus.out_reg), 32'(pend_data));
`ifdef REG_ARB_LAST_WRITER_EN
                check("last_writer", 32'(bus.last_writer), 32'(pend_lw));
`endif
                pend = 1'b0;
            end
            if (bus.ack !== '0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ack: got ack=%b expected none at %0t", bus.ack, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("ack", 32'(bus.ack), 32'(e[EW-1 -: N]));
                    check("busy_write", 32'(bus.busy), 32'd1);
                    pend      = 1'b1;
                    pend_data = e[IW +: W];
                    pend_lw   = e[IW-1:0];
                end
            end else begin
                check("busy_idle", 32'(bus.busy), 32'd0);
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.req      = 4'b1111;
        bus.req_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};

        // reset held 3 cycles with all requests up
        repeat (3) begin
            tick();
            mon_en = 1'b1;
            check("reset_out_reg", 32'(bus.out_reg), 32'd0);
`ifdef REG_ARB_LAST_WRITER_EN
            check("reset_last_writer", 32'(bus.last_writer), 32'd0);
`endif
        end

        // full contention: 0,1,2,3,0
        push_exp(0, 16'h0001, 2'd0);
        push_exp(1, 16'h0002, 2'd1);
        push_exp(2, 16'h0003, 2'd2);
        push_exp(3, 16'h0004, 2'd3);
        push_exp(0, 16'h0001, 2'd0);
        rst_n = 1'b1;
        repeat (9) tick();
        bus.req = '0;
        tick();
        tick();

        // single request from requester 2
        bus.req = 4'b0100;
        set_slot(2, 16'hBEEF);
        push_exp(2, 16'hBEEF, 2'd2);
        tick();
        bus.req = '0;
        tick();
        tick();

        // pointer at 3: 0 wins by wrap, then 2; data change after grant is ignored
        bus.req = 4'b0101;
        set_slot(0, 16'h1111);
        set_slot(2, 16'h2222);
        push_exp(0, 16'h1111, 2'd0);
        push_exp(2, 16'h2222, 2'd2);
        tick();
        bus.req = 4'b0100;
        set_slot(0, 16'h9999);
        tick();
        tick();
        bus.req = '0;
        tick();
        tick();

        // writes from 3 then 1
        bus.req = 4'b1000;
        set_slot(3, 16'h3333);
        push_exp(3, 16'h3333, 2'd3);
        tick();
        bus.req = '0;
        tick();
        tick();
        bus.req = 4'b0010;
        set_slot(1, 16'h4444);
        push_exp(1, 16'h4444, 2'd1);
        tick();
        bus.req = '0;
        tick();
        tick();

        // reset at the edge closing WRITE: commit aborted, register cleared
        bus.req = 4'b0001;
        set_slot(0, 16'hAAAA);
        push_exp(0, 16'h0000, 2'd0);
        tick();
        bus.req = '0;
        rst_n   = 1'b0;
        tick();
        check("abort_out_reg", 32'(bus.out_reg), 32'd0);
        rst_n = 1'b1;
        tick();

        // pointer must be back at 0: req 0011 grants 0 first, then 1
        bus.req = 4'b0011;
        set_slot(0, 16'h0F0F);
        set_slot(1, 16'hF0F0);
        push_exp(0, 16'h0F0F, 2'd0);
        push_exp(1, 16'hF0F0, 2'd1);
        tick();
        bus.req = 4'b0010;
        tick();
        tick();
        bus.req = '0;
        tick();
        tick();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drain_expected_acks", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
